// File: rtl/wb_arbiter.sv
// wb_arbiter
// Writeback arbiter sitting directly in front of the register file write port.
// The in-order pipeline writeback owns the port whenever it has a real write
// (fixed priority, no backpressure). Multdiv results are queued in a small
// FIFO and drain into any free slot. A per-register busy vector marks
// destinations that still have a multdiv result queued.
//
// Optional feature: define WB_ARBITER_STARVE_EN to build the starvation
// counter that raises pipe_stall for one cycle after STARVE_MAX consecutive
// cycles in which a queued result could not drain. Without the macro,
// pipe_stall is tied low and queued results may wait indefinitely.
module wb_arbiter #(
    parameter int DEPTH      = 4,   // FIFO entries, power of 2, >= 2
    parameter int STARVE_MAX = 8    // starved cycles before a bubble request
) (
    input  logic                   clock,
    input  logic                   ctrl_reset_n,
    input  logic                   pipe_valid,
    input  logic [4:0]             pipe_rd,
    input  logic [31:0]            pipe_data,
    input  logic                   md_valid,
    output logic                   md_ready,
    input  logic [4:0]             md_rd,
    input  logic [31:0]            md_data,
    output logic                   ctrl_writeEnable,
    output logic [4:0]             ctrl_writeReg,
    output logic [31:0]            data_writeReg,
    output logic [31:0]            busy,
    output logic                   pipe_stall,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int PW = $clog2(DEPTH);  // pointer width
    localparam int CW = PW + 1;         // occupancy width (0..DEPTH)

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // FIFO payload storage. The head is read asynchronously so a pop can be
    // loaded straight into the output registers on the same edge; with only
    // a handful of entries this maps to distributed storage.
    logic [4:0]    rdMem   [DEPTH];
    logic [31:0]   dataMem [DEPTH];

    logic [PW-1:0] headPtrReg;
    logic [PW-1:0] tailPtrReg;
    logic [CW-1:0] countReg;
    logic [31:0]   busyReg;

    logic          weReg;
    logic [4:0]    wregReg;
    logic [31:0]   wdataReg;

    // ------------------------------------------------------------------
    // Slot arbitration and FIFO handshakes
    // ------------------------------------------------------------------
    logic          pipeWrite;   // pipeline owns the write port this cycle
    logic          slotFree;    // no real pipeline write (includes writes to r0)
    logic          fifoEmpty;
    logic          mdAccept;    // multdiv handshake completes at this edge
    logic          mdPush;      // accepted result with a real destination
    logic          mdPop;       // head drains into the free slot
    logic [4:0]    headRd;
    logic [31:0]   headData;

    assign fifoEmpty = (countReg == '0);

    // No pass-through: readiness depends only on the registered occupancy,
    // so a full FIFO refuses a new result even on a cycle it drains one.
    assign md_ready  = (countReg < CW'(DEPTH));

    assign pipeWrite = pipe_valid && (pipe_rd != 5'd0);
    assign slotFree  = !pipeWrite;
    assign mdAccept  = md_valid && md_ready;
    assign mdPush    = mdAccept && (md_rd != 5'd0);
    assign mdPop     = slotFree && !fifoEmpty;

    assign headRd    = rdMem[headPtrReg];
    assign headData  = dataMem[headPtrReg];

    // ------------------------------------------------------------------
    // Busy scoreboard
    // ------------------------------------------------------------------
    // dupMatch[gi] flags a queued entry, other than the head, whose
    // destination equals the head's. If any exists, popping the head must
    // leave the busy bit set because that register is still pending.
    logic [DEPTH-1:0] dupMatch;
    logic             headShared;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dup
            logic [PW-1:0] offset;   // distance of slot gi behind the head
            assign offset       = PW'(gi) - headPtrReg;
            assign dupMatch[gi] = (offset != '0)
                               && ({1'b0, offset} < countReg)
                               && (rdMem[gi] == headRd);
        end
    endgenerate

    assign headShared = |dupMatch;

    logic [31:0] busyNext;

    // Clear on pop unless still pending, then set on push so a same-edge set wins.
    always_comb begin
        busyNext = busyReg;
        if (mdPop && !headShared) begin
            busyNext[headRd] = 1'b0;
        end
        if (mdPush) begin
            busyNext[md_rd] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    // FIFO payload write at the tail; contents need no reset because the
    // pointers and occupancy define which slots are meaningful.
    always_ff @(posedge clock) begin
        if (mdPush) begin
            rdMem[tailPtrReg]   <= md_rd;
            dataMem[tailPtrReg] <= md_data;
        end
    end

    // FIFO pointers, occupancy and busy vector; reset flushes the queue.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            headPtrReg <= '0;
            tailPtrReg <= '0;
            countReg   <= '0;
            busyReg    <= '0;
        end else begin
            if (mdPush) begin
                tailPtrReg <= tailPtrReg + PW'(1);
            end
            if (mdPop) begin
                headPtrReg <= headPtrReg + PW'(1);
            end
            case ({mdPush, mdPop})
                2'b10:   countReg <= countReg + CW'(1);
                2'b01:   countReg <= countReg - CW'(1);
                default: countReg <= countReg;
            endcase
            busyReg <= busyNext;
        end
    end

    // Regfile write port: pipeline first, then FIFO head, otherwise idle
    // with address and data holding their last values.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            weReg    <= 1'b0;
            wregReg  <= 5'd0;
            wdataReg <= 32'd0;
        end else if (pipeWrite) begin
            weReg    <= 1'b1;
            wregReg  <= pipe_rd;
            wdataReg <= pipe_data;
        end else if (mdPop) begin
            weReg    <= 1'b1;
            wregReg  <= headRd;
            wdataReg <= headData;
        end else begin
            weReg    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Starvation bubble request (optional)
    // ------------------------------------------------------------------
`ifdef WB_ARBITER_STARVE_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starveCntReg;
    logic [SW-1:0] starveCntNext;
    logic          stallReg;

    // Count consecutive cycles with a queued result but no pop; saturate so
    // the request fires only on the cycle the limit is first reached.
    always_comb begin
        starveCntNext = starveCntReg;
        if (mdPop || fifoEmpty) begin
            starveCntNext = '0;
        end else if (starveCntReg != SW'(STARVE_MAX)) begin
            starveCntNext = starveCntReg + SW'(1);
        end
    end

    // One-cycle bubble request; the pipeline leaves the next slot free so
    // the head drains and the counter restarts.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            starveCntReg <= '0;
            stallReg     <= 1'b0;
        end else begin
            starveCntReg <= starveCntNext;
            stallReg     <= (starveCntNext == SW'(STARVE_MAX))
                         && (starveCntReg != SW'(STARVE_MAX));
        end
    end

    assign pipe_stall = stallReg;
`else
    // STARVE_MAX only matters when the bubble request is built in.
    logic unusedStarveMax;
    assign unusedStarveMax = (STARVE_MAX > 0);
    assign pipe_stall      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ctrl_writeEnable = weReg;
    assign ctrl_writeReg    = wregReg;
    assign data_writeReg    = wdataReg;
    assign busy             = busyReg;
    assign fifo_count       = countReg;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter. Each driven cycle pushes
// the expected regfile write onto a queue; after the clock edge the entry is
// popped and compared with the registered write port, occupancy, busy
// vector and bubble request.
module tb_wb_arbiter;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] busy;
    logic        pipe_stall;
    logic [2:0]  fifo_count;

    always #5 clock = ~clock;

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .pipe_valid       (pipe_valid),
        .pipe_rd          (pipe_rd),
        .pipe_data        (pipe_data),
        .md_valid         (md_valid),
        .md_ready         (md_ready),
        .md_rd            (md_rd),
        .md_data          (md_data),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .busy             (busy),
        .pipe_stall       (pipe_stall),
        .fifo_count       (fifo_count)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } ExpWrite;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } MdEntry;

    ExpWrite     expQ[$];     // scoreboard of expected write-port states
    MdEntry      fifoM[$];    // reference multdiv queue
    logic [4:0]  lastRdM;
    logic [31:0] lastDataM;
    int          starveM;
    logic        stallM;
    int          totalCnt = 0;
    int          badCnt   = 0;
    int          cycNum   = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // A register is pending exactly when some queued entry targets it.
    function automatic logic [31:0] busyModel();
        logic [31:0] b;
        b = '0;
        foreach (fifoM[i]) b[fifoM[i].rd] = 1'b1;
        return b;
    endfunction

    task automatic resetModel();
        expQ.delete();
        fifoM.delete();
        lastRdM   = 5'd0;
        lastDataM = 32'd0;
        starveM   = 0;
        stallM    = 1'b0;
    endtask

    // Drive one cycle (called just after a falling edge), predict, then check.
    task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pdat,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
        ExpWrite e;
        ExpWrite got;
        MdEntry  ent;
        logic    readyM, slotFreeM, popM, pushM;
        int      newCnt;
        logic    stallNextM;
`ifdef WB_ARBITER_STARVE_EN
        if (stallM) pv = 1'b0;   // upstream honours the bubble request
`endif
        pipe_valid = pv;
        pipe_rd    = prd;
        pipe_data  = pdat;
        md_valid   = mv;
        md_rd      = mrd;
        md_data    = mdat;

        readyM = (fifoM.size() < DEPTH);
        #1;
        checkVal("md_ready", md_ready, readyM);

        slotFreeM = !(pv && (prd != 5'd0));
        popM      = slotFreeM && (fifoM.size() != 0);
        pushM     = mv && readyM && (mrd != 5'd0);

        if (!slotFreeM) begin
            e.we = 1'b1; e.rd = prd; e.data = pdat;
        end else if (popM) begin
            e.we = 1'b1; e.rd = fifoM[0].rd; e.data = fifoM[0].data;
        end else begin
            e.we = 1'b0; e.rd = lastRdM; e.data = lastDataM;
        end

        stallNextM = 1'b0;
        newCnt     = 0;
`ifdef WB_ARBITER_STARVE_EN
        if (popM || fifoM.size() == 0) newCnt = 0;
        else if (starveM < STARVE_MAX) newCnt = starveM + 1;
        else newCnt = starveM;
        stallNextM = (newCnt == STARVE_MAX) && (starveM != STARVE_MAX);
`endif
        starveM = newCnt;

        if (popM) void'(fifoM.pop_front());
        if (pushM) begin
            ent.rd = mrd; ent.data = mdat;
            fifoM.push_back(ent);
        end
        lastRdM   = e.rd;
        lastDataM = e.data;
        expQ.push_back(e);

        @(posedge clock);
        #1;
        stallM = stallNextM;
        got = expQ.pop_front();
        checkVal("write_enable", ctrl_writeEnable, got.we);
        checkVal("write_reg", ctrl_writeReg, got.rd);
        checkVal("write_data", data_writeReg, got.data);
        checkVal("fifo_count", fifo_count, fifoM.size());
        checkVal("busy", busy, busyModel());
        checkVal("pipe_stall", pipe_stall, stallM);
        cycNum++;
        $display("cyc %0d: we=%0b reg=%0d data=%08h cnt=%0d busy=%08h stall=%0b",
                 cycNum, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
                 fifo_count, busy, pipe_stall);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, "_we"},     ctrl_writeEnable, 1'b0);
        checkVal({tag, "_reg"},    ctrl_writeReg, 5'd0);
        checkVal({tag, "_data"},   data_writeReg, 32'd0);
        checkVal({tag, "_busy"},   busy, 32'd0);
        checkVal({tag, "_count"},  fifo_count, 3'd0);
        checkVal({tag, "_stall"},  pipe_stall, 1'b0);
        checkVal({tag, "_ready"},  md_ready, 1'b1);
    endtask

    // Global time bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "time limit reached");
    end

    initial begin
        pipe_valid = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
        md_valid   = 1'b0; md_rd   = 5'd0; md_data   = 32'd0;
        ctrl_reset_n = 1'b0;
        resetModel();
        repeat (3) @(posedge clock);
        #1;
        checkResetState("reset");
        @(negedge clock);
        ctrl_reset_n = 1'b1;

        // Pipeline write, latency one, then idle holds address/data.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        idle(1);

        // Single multdiv result through an idle pipeline.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678);
        idle(2);

        // Pipeline hogs the port on r3 while multdiv fills the FIFO and then
        // keeps offering a fifth result; afterwards the queue drains in order.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 5'd3, 32'h300 + i,
                 (i < 6), (i < 4) ? 5'(10 + i) : 5'd14,
                 (i < 4) ? 32'hA0 + i : 32'hAE);
        end
        idle(7);

        // Two results to r9 queued together: busy survives the first pop.
        step(1'b1, 5'd3, 32'h3A, 1'b1, 5'd9, 32'd1);
        step(1'b1, 5'd3, 32'h3B, 1'b1, 5'd9, 32'd2);
        idle(3);

        // Writes to r0 from both sources vanish.
        step(1'b1, 5'd0, 32'hBAD0, 1'b1, 5'd0, 32'hBAD1);
        idle(1);

        // Mixed traffic with repeated destinations and pointer wrap.
        for (int i = 0; i < 60; i++) begin
            logic [4:0] rdSel;
            rdSel = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'(4 + $urandom_range(0, 2));
            step($urandom_range(0, 2) == 0, 5'($urandom_range(0, 6)), $urandom,
                 $urandom_range(0, 1) == 1, rdSel, $urandom);
        end
        idle(8);

        // Reset in the middle of a cycle with three results queued.
        step(1'b1, 5'd3, 32'h31, 1'b1, 5'd20, 32'h20);
        step(1'b1, 5'd3, 32'h32, 1'b1, 5'd21, 32'h21);
        step(1'b1, 5'd3, 32'h33, 1'b1, 5'd22, 32'h22);
        checkVal("prereset_count", fifo_count, 3'd3);
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        checkResetState("midreset");
        @(posedge clock);
        #1;
        checkResetState("heldreset");
        @(negedge clock);
        pipe_valid = 1'b0; md_valid = 1'b0;
        ctrl_reset_n = 1'b1;
        resetModel();
        idle(5);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter directly upstream of the register file write port.
- Merges two result sources into the single regfile write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg):
  - the in-order pipeline writeback, which has fixed priority and no backpressure;
  - the long-latency multdiv result, buffered in a small FIFO.
- Keeps a per-register busy scoreboard so the hazard unit can stall reads of pending destinations.

Parameters:
- DEPTH, 4, multdiv result FIFO entries; power of 2, at least 2.
- STARVE_MAX, 8, consecutive starved cycles before requesting a pipeline bubble (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- ctrl_reset_n  in  1  asynchronous active-low reset.
- pipe_valid  in  1  pipeline writeback valid this cycle.
- pipe_rd  in  5  pipeline destination register.
- pipe_data  in  32  pipeline result.
- md_valid  in  1  multdiv result valid.
- md_ready  out  1  arbiter can accept a multdiv result.
- md_rd  in  5  multdiv destination register.
- md_data  in  32  multdiv result.
- ctrl_writeEnable  out  1  regfile write enable (registered).
- ctrl_writeReg  out  5  regfile write address (registered).
- data_writeReg  out  32  regfile write data (registered).
- busy  out  32  bit r = 1 means a multdiv result for register r is pending.
- pipe_stall  out  1  request one pipeline writeback bubble.
- fifo_count  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, asynchronous, ctrl_reset_n=0:
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
  - busy=0, pipe_stall=0, fifo_count=0.
  - FIFO is flushed; any in-flight entries are discarded.
  - Applies immediately, including mid-operation.
- Pipeline path, latency 1:
  - If pipe_valid=1 and pipe_rd!=0 at edge E, the outputs after E are WE=1, reg=pipe_rd, data=pipe_data.
  - Otherwise the slot is free.
- Free slot: pipe_valid=0, or pipe_valid=1 with pipe_rd=0. A pipeline write to r0 is dropped and the slot is treated as free.
- Multdiv accept:
  - The handshake occurs at an edge where md_valid=1 and md_ready=1.
  - md_ready = (fifo_count < DEPTH). There is no same-cycle pass-through; a full FIFO deasserts md_ready even while a pop is in progress.
  - md_rd!=0: the entry is pushed and busy[md_rd] is set.
  - md_rd=0: the result is accepted and discarded; no push, busy unchanged.
- Multdiv drain, minimum latency 2:
  - At an edge where the slot is free and the FIFO is non-empty, the head is popped into the output registers: WE=1, reg=head.rd, data=head.data.
  - An accept at edge E can therefore reach the outputs no earlier than after edge E+1.
- Idle: WE=0; reg and data hold their previous values.
- Simultaneous push and pop: fifo_count is unchanged; head and tail pointers wrap modulo DEPTH.
- Busy clear:
  - On a pop, busy[head.rd] is cleared unless another remaining FIFO entry has the same rd.
  - If a push sets the same bit on the same edge, the set wins.
- Ordering and hazards:
  - FIFO order is strict; multdiv results retire in acceptance order.
  - No WAW checking is done here. The hazard unit stalls the pipeline on busy.
- Writes are ordered so that the value visible in the regfile after the write edge is the value from the cycle that owned the slot.

Optional Feature:
- Macro WB_ARBITER_STARVE_EN.
- Defined:
  - A counter increments each cycle the FIFO is non-empty and no pop occurs; it resets to 0 on any pop or when the FIFO is empty.
  - When the counter reaches STARVE_MAX, pipe_stall is registered high for exactly one cycle.
  - The upstream pipeline guarantees pipe_valid=0 in the following cycle, so that slot drains the head. The counter then resets.
  - pipe_stall resets to 0.
- Not defined: pipe_stall is tied to 0, no counter logic exists, and multdiv results may starve indefinitely.

Test Plan:
- Reset then pipe_valid=1, pipe_rd=5, pipe_data=0xDEADBEEF -> one cycle later WE=1, reg=5, data=0xDEADBEEF; the next cycle WE=0.
- md push rd=7, data=0x12345678 with the pipeline idle -> busy[7]=1 after the accept edge; WE=1, reg=7 one edge later; busy[7]=0 after the pop.
- Pipeline continuously writing r3 while md pushes 4 entries, DEPTH=4 -> md_ready=0 at fifo_count=4, no regfile writes from the FIFO. With the macro, pipe_stall pulses after 8 starved cycles and entries drain in order.
- Two md pushes to rd=9 (data 1, then data 2) -> busy[9] stays 1 after the first pop and clears after the second; the final regfile write is data 2.
- md rd=0 accepted and pipeline pipe_rd=0 -> no WE pulse, busy unchanged, fifo_count=0.
- Assert ctrl_reset_n=0 mid-cycle with 3 entries queued -> outputs, busy and fifo_count go to 0 immediately; no writes occur after release.
